activations_writer: RTL and testbench

- Write-back packer for the output activation path: the inverse of the memory-to-lane activation driver.
- Accepts a stream of narrow activation beats from the PE array, each IN_LANES x IO_DATA_WIDTH bits wide.
- Packs beats MSB-first into MEM_BW-wide SRAM words and issues them as sequential-address writes under a valid/ready handshake.
- Supports a partial final word, zero-padded, followed by a done pulse.

---
 rtl/activations_writer.sv | 112 +++++++++++
 tb/tb_activations_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/activations_writer.sv
// Write-back packer: packs narrow PE-array activation beats MSB-first into
// SRAM words and issues them as sequential-address writes with a done pulse.
module activations_writer #(
  parameter int IO_DATA_WIDTH = 8,
  parameter int MEM_BW        = 128,
  parameter int IN_LANES      = 4,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_LANES*IO_DATA_WIDTH-1:0] in_data,
  input  logic                              in_last,
  output logic                              mem_we,
  input  logic                              mem_ready,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [MEM_BW-1:0]                 mem_wdata,
  output logic                              busy,
  output logic                              done
);

  // state | meaning
  // IDLE  | waiting for start; input stream blocked
  // RUN   | accepting beats, closing words into the output register
  // DRAIN | last word closed; waiting for the final write to be taken

  localparam int BEAT_W = IN_LANES * IO_DATA_WIDTH;
  localparam int BEATS  = MEM_BW / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, next_state;
  logic [CNT_W-1:0]      beat_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [MEM_BW-1:0]     pack, pack_next;
  logic [31:0]           shift_amt;
  logic                  last_slot, accept, closure;

  assign last_slot = (beat_cnt == CNT_W'(BEATS - 1));
  assign accept    = in_valid && in_ready;
  assign closure   = accept && (last_slot || in_last);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        // A closing beat can only go in if the output register is free or
        // being emptied this cycle.
        in_ready = (!last_slot && !in_last) || !mem_we || mem_ready;
        if (accept && in_last) next_state = DRAIN;
      end
      DRAIN: begin
        if (!mem_we) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Current beat merged into the pack; slots not yet written stay zero.
  always_comb begin
    shift_amt = 32'(beat_cnt) * 32'(BEAT_W);
    pack_next = pack;
    if (accept)
      pack_next = pack | ({in_data, {(MEM_BW-BEAT_W){1'b0}}} >> shift_amt);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      beat_cnt  <= '0;
      addr_cnt  <= '0;
      pack      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr_cnt <= base_addr;
        beat_cnt <= '0;
        pack     <= '0;
      end
      if (mem_we && mem_ready && !closure) mem_we <= 1'b0;
      if (closure) begin
        mem_wdata <= pack_next;
        mem_addr  <= addr_cnt;
        mem_we    <= 1'b1;
        addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
        pack      <= '0;
        beat_cnt  <= '0;
      end else if (accept) begin
        pack     <= pack_next;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_activations_writer.sv
// Scoreboard bench for activations_writer: expected writes are queued as beats
// are driven and compared when the SRAM side takes each write.
module tb_activations_writer;

  logic         clk = 1'b0;
  logic         arst;
  logic         start;
  logic [15:0]  base_addr;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         mem_we;
  logic         mem_ready;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         busy;
  logic         done;

  activations_writer dut (
    .clk(clk), .arst(arst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0, wr_cnt = 0, done_cnt = 0, write_cyc = 0, done_cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!arst && mem_we && mem_ready) begin
      wr_cnt++;
      write_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_write", 128'(mem_addr), 128'hffff_ffff);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 128'(mem_addr), 128'(e.addr));
        chk("wr_data", mem_wdata, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
    wr_t e;
    e.addr = a;
    e.data = {b0, b1, b2, b3};
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] a);
    start = 1'b1;
    base_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("beat_accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk(tag, 128'(done_cnt - d0), 128'd1);
  endtask

  initial begin
    logic [127:0] held_data;
    int           d_before, w_before;
    arst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {mem_we, in_ready, busy, done, mem_addr, mem_wdata[107:0]}, 128'd0);
    @(posedge clk); #1 arst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_in_ready", 128'(in_ready), 128'd0);

    // full word
    @(posedge clk); #1;
    do_start(16'h0010);
    push_wr(16'h0010, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
    send_beat(32'h00010203, 1'b0);
    send_beat(32'h04050607, 1'b0);
    send_beat(32'h08090A0B, 1'b0);
    send_beat(32'h0C0D0E0F, 1'b1);
    wait_done("full_done");
    chk("full_done_latency", 128'(done_cyc - write_cyc), 128'd1);
    chk("full_busy_after", 128'(busy), 128'd0);

    // partial final word
    do_start(16'h0020);
    push_wr(16'h0020, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    push_wr(16'h0021, 32'h55555555, 32'h66666666, 32'h0, 32'h0);
    for (int i = 1; i <= 6; i++) send_beat({4{i[7:0] * 8'h11}}, i == 6);
    wait_done("partial_done");
    repeat (4) @(posedge clk);
    chk("partial_single_done", 128'(done_cyc > write_cyc), 128'd1);

    // backpressure
    mem_ready = 1'b0;
    do_start(16'h0030);
    push_wr(16'h0030, 32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003);
    push_wr(16'h0031, 32'hB0000004, 32'hB0000005, 32'hB0000006, 32'hB0000007);
    for (int i = 0; i < 4; i++) send_beat(32'hB0000000 + 32'(i), 1'b0);
    fork
      begin
        @(negedge clk);
        held_data = mem_wdata;
        chk("bp_we", 128'(mem_we), 128'd1);
        repeat (4) begin
          @(negedge clk);
          chk("bp_addr_hold", 128'(mem_addr), 128'h0030);
          chk("bp_data_hold", mem_wdata, held_data);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
      end
      begin
        for (int i = 4; i < 7; i++) send_beat(32'hB0000000 + 32'(i), 1'b0);
        in_valid = 1'b1; in_data = 32'hB0000007; in_last = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", 128'(in_ready), 128'd0);
        send_beat(32'hB0000007, 1'b1);
      end
    join
    wait_done("bp_done");

    // address wrap
    do_start(16'hFFFF);
    push_wr(16'hFFFF, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003);
    push_wr(16'h0000, 32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007);
    for (int i = 0; i < 8; i++) send_beat(32'hA0000000 + 32'(i), i == 7);
    wait_done("wrap_done");

    // reset mid-job: pending word dropped, nothing queued for it
    mem_ready = 1'b0;
    do_start(16'h0040);
    for (int i = 0; i < 6; i++) send_beat(32'hDEAD0000 + 32'(i), 1'b0);
    chk("mid_we_pending", 128'(mem_we), 128'd1);
    arst = 1'b1;
    #1;
    chk("mid_rst_outputs", {mem_we, in_ready, busy, done, mem_addr, mem_wdata[107:0]}, 128'd0);
    chk("mid_rst_wdata_hi", 128'(mem_wdata[127:108]), 128'd0);
    #1 arst = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    do_start(16'h0005);
    push_wr(16'h0005, 32'h50505050, 32'h0, 32'h0, 32'h0);
    send_beat(32'h50505050, 1'b1);
    wait_done("post_rst_done");

    // protocol guard
    w_before = wr_cnt;
    in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("guard_idle_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    chk("guard_idle_no_write", 128'(wr_cnt - w_before), 128'd0);
    do_start(16'h0050);
    push_wr(16'h0050, 32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003);
    push_wr(16'h0051, 32'hC0000004, 32'hC0000005, 32'hC0000006, 32'hC0000007);
    send_beat(32'hC0000000, 1'b0);
    send_beat(32'hC0000001, 1'b0);
    do_start(16'h0090);
    for (int i = 2; i < 8; i++) send_beat(32'hC0000000 + 32'(i), i == 7);
    wait_done("guard_done");
    d_before = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("guard_no_extra_job", 128'({busy, 8'(done_cnt - d_before)}), 128'd0);

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    chk("total_writes", 128'(wr_cnt), 128'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=%0d exp=0", cyc);
    $fatal(1);
  end

endmodule
